mem_stage: RTL

//  MEM pipeline stage directly downstream of EX (fed via EX/MEM register). ALU results pass

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_load_ext.sv | 25 ++
 rtl/mem_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Memory-op codes, bus widths, common constants, FSM state codes and small decode helpers.
package mem_stage_pkg;

    localparam int unsigned MemOpBus = 4;

    localparam logic [MemOpBus-1:0] MEM_NOP = 4'd0;
    localparam logic [MemOpBus-1:0] MEM_LB  = 4'd1;
    localparam logic [MemOpBus-1:0] MEM_LH  = 4'd2;
    localparam logic [MemOpBus-1:0] MEM_LW  = 4'd3;
    localparam logic [MemOpBus-1:0] MEM_LBU = 4'd4;
    localparam logic [MemOpBus-1:0] MEM_LHU = 4'd5;
    localparam logic [MemOpBus-1:0] MEM_SB  = 4'd6;
    localparam logic [MemOpBus-1:0] MEM_SH  = 4'd7;
    localparam logic [MemOpBus-1:0] MEM_SW  = 4'd8;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NopRegAddr = 5'd0;
    localparam logic        Enable     = 1'b1;
    localparam logic        Disable    = 1'b0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StXfer = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Unknown encodings fall out as non-memory ops, i.e. ALU pass-through.
    function automatic logic is_mem_op(input logic [MemOpBus-1:0] op);
        return (op >= MEM_LB) && (op <= MEM_SW);
    endfunction

    function automatic logic is_store(input logic [MemOpBus-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Index of the last byte of the access (N-1).
    function automatic logic [1:0] op_last(input logic [MemOpBus-1:0] op);
        logic [1:0] last;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: last = 2'd1;
            MEM_LW, MEM_SW:          last = 2'd3;
            default:                 last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extension for the MEM stage.
// Ports:
//   op    - memory op of the completed load
//   data  - little-endian assembled load bytes (unused upper bytes are don't-care)
//   ext   - write-back value: sign-extended for LB/LH, zero-extended for LBU/LHU, raw for LW
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [MemOpBus-1:0] op,
    input  logic [31:0]         data,
    output logic [31:0]         ext
);

    always_comb begin
        ext = data;
        case (op)
            MEM_LB:  ext = {{24{data[7]}}, data[7:0]};
            MEM_LH:  ext = {{16{data[15]}}, data[15:0]};
            MEM_LBU: ext = {24'h00_0000, data[7:0]};
            MEM_LHU: ext = {16'h0000, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage.
// ALU results pass straight through to MEM/WB; loads and stores run byte-serially on an
// 8-bit RAM port while stall_o holds the upstream pipeline.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rdy_i               - global ready, 0 freezes the access
//   memop_i, maddr_i, sdata_i, wreg_i, waddr_i, wdata_i - from EX/MEM register
//   mem_din_i           - RAM read byte (valid the cycle after its address)
//   mem_a_o, mem_dout_o, mem_wr_o - RAM byte address, write byte, write strobe
//   stall_o             - upstream stall request
//   wreg_o, waddr_o, wdata_o - to MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy_i,
    input  logic [MemOpBus-1:0] memop_i,
    input  logic [ADDR_W-1:0]   maddr_i,
    input  logic [31:0]         sdata_i,
    input  logic                wreg_i,
    input  logic [4:0]          waddr_i,
    input  logic [31:0]         wdata_i,
    input  logic [7:0]          mem_din_i,
    output logic [ADDR_W-1:0]   mem_a_o,
    output logic [7:0]          mem_dout_o,
    output logic                mem_wr_o,
    output logic                stall_o,
    output logic                wreg_o,
    output logic [4:0]          waddr_o,
    output logic [31:0]         wdata_o
);

    logic [1:0]          state_q, state_d;
    logic [1:0]          cnt_q;
    logic [MemOpBus-1:0] op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   a_last_q;
    logic [31:0]         sdata_q;
    logic [4:0]          waddr_q;
    logic [31:0]         ld_q;

    logic [ADDR_W-1:0]   xfer_addr;
    logic [1:0]          last_idx;
    logic [1:0]          prev_idx;
    logic                st_q;
    logic [31:0]         ld_ext;

    assign xfer_addr = addr_q + ADDR_W'(cnt_q);
    assign last_idx  = op_last(op_q);
    assign prev_idx  = cnt_q - 2'd1;
    assign st_q      = is_store(op_q);

    mem_load_ext u_load_ext (
        .op   (op_q),
        .data (ld_q),
        .ext  (ld_ext)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (is_mem_op(memop_i)) state_d = StXfer;
            StXfer: if (cnt_q == last_idx) state_d = st_q ? StDone : StWait;
            StWait: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            op_q     <= MEM_NOP;
            addr_q   <= '0;
            a_last_q <= '0;
            sdata_q  <= ZeroWord;
            waddr_q  <= NopRegAddr;
            ld_q     <= ZeroWord;
        end else if (rdy_i) begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (is_mem_op(memop_i)) begin
                        op_q    <= memop_i;
                        addr_q  <= maddr_i;
                        sdata_q <= sdata_i;
                        waddr_q <= waddr_i;
                        cnt_q   <= 2'd0;
                        ld_q    <= ZeroWord;
                    end
                end
                StXfer: begin
                    a_last_q <= xfer_addr;
                    cnt_q    <= cnt_q + 2'd1;
                    // Byte addressed in the previous XFER cycle is on mem_din_i now.
                    if (!st_q && (cnt_q != 2'd0)) begin
                        ld_q[{prev_idx, 3'b000} +: 8] <= mem_din_i;
                    end
                end
                StWait: begin
                    ld_q[{last_idx, 3'b000} +: 8] <= mem_din_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wreg_o     = Disable;
        waddr_o    = NopRegAddr;
        wdata_o    = ZeroWord;
        stall_o    = Disable;
        mem_wr_o   = Disable;
        mem_a_o    = a_last_q;
        mem_dout_o = 8'h00;
        if (rst) begin
            mem_a_o = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_mem_op(memop_i)) begin
                        stall_o = Enable;
                    end else begin
                        wreg_o  = wreg_i;
                        waddr_o = waddr_i;
                        wdata_o = wdata_i;
                    end
                end
                StXfer: begin
                    stall_o = Enable;
                    mem_a_o = xfer_addr;
                    if (st_q) begin
                        mem_wr_o   = rdy_i;
                        mem_dout_o = sdata_q[{cnt_q, 3'b000} +: 8];
                    end
                end
                StWait: begin
                    stall_o = Enable;
                end
                default: begin
                    if (!st_q) begin
                        wreg_o  = Enable;
                        waddr_o = waddr_q;
                        wdata_o = ld_ext;
                    end
                end
            endcase
        end
    end

endmodule
